uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one byte-level UART transmitter among `NUM_REQ` independent requesters, such as a status reporter, an echo path from the receiver and a debug dump. It selects requesters round-robin and locks the grant for a whole message, until the requester's `last` byte is accepted. A stalled requester is released by timeout. The block sits between the requesters and the transmit serializer, which accepts one byte per valid/ready handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8, any value (not restricted to powers of two).
- `TIMEOUT_CYCLES`, default 27_000: idle cycles tolerated mid-message before forced release (1 ms at 27 MHz).
- `ID_W`: derived localparam, `$clog2(NUM_REQ)`.
- `clk` in 1: system clock, 27 MHz.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*8: requester i byte at `[8i+7:8i]`.
- `req_last` in NUM_REQ: marks the final byte of a message.
- `req_ready` out NUM_REQ: per-requester accept; at most one bit high.
- `tx_valid` out 1: byte offered to the serializer.
- `tx_data` out 8: byte to the serializer.
- `tx_ready` in 1: serializer accepts a byte.
- `grant_id` out ID_W: current or last granted requester.
- `busy` out 1: a grant is held (state LOCKED).
- `timeout_err` out 1: one-cycle pulse on forced release.

## Operation
- The state machine has two states, IDLE and LOCKED, plus a round-robin pointer `rr_ptr`.
- **Reset values:**
  - state = IDLE
  - `rr_ptr` = 0
  - `grant_id` = 0
  - `busy` = 0
  - `timeout_err` = 0
  - idle counter = 0
  - `tx_valid` = 0
  - `req_ready` = 0
- **IDLE:**
  - `tx_valid` = 0 and `req_ready` = 0.
  - If any `req_valid` is high, register as `grant_id` the first set index found scanning upward from `rr_ptr` with wrap from NUM_REQ-1 to 0.
  - Then go to LOCKED.
- **LOCKED (grant g), combinational pass-through:**
  - `tx_valid` = `req_valid[g]`
  - `tx_data` = `req_data[g]`
  - `req_ready[g]` = `tx_ready`
  - All other `req_ready` bits are 0.
- **End of message:** on a handshake (`req_valid[g]` & `tx_ready`) with `req_last[g]` = 1:
  - state goes to IDLE.
  - `rr_ptr` becomes (g+1) mod NUM_REQ.
- **Idle counter:**
  - Clears on any handshake and whenever `req_valid[g]` = 1.
  - Increments while `req_valid[g]` = 0 in LOCKED.
- **Forced release:** when the counter reaches TIMEOUT_CYCLES-1 while `req_valid[g]` = 0:
  - state goes to IDLE.
  - `rr_ptr` becomes (g+1) mod NUM_REQ.
  - `timeout_err` = 1 for one cycle.
  - The counter clears.
- **Simultaneous events:** a timeout and a handshake cannot coincide, because the counter only advances with valid low.
- **Width rule:** counter width is `$clog2(TIMEOUT_CYCLES)`. The modulo in the pointer advance is an explicit compare, not truncation.
- **Handshake rules:**
  - A requester must hold valid, data and last stable until it sees ready.
  - Requesters not granted are simply not served; no bytes are dropped.

## Timing
- **Grant latency:** `req_valid` high in IDLE at cycle n gives `busy` = 1 and the registered `grant_id` at n+1. The first `tx_valid` can appear at n+1.
- **Back-to-back bytes:** within a message, one byte per cycle if the serializer allows it. There is zero added latency, since the data path is combinational.
- **Between messages:** exactly one IDLE cycle, in which `tx_valid` = 0.
- **`grant_id` after release:** holds its value in IDLE until the next grant.
- **Reset mid-message:** state, counter and pointer clear immediately. `tx_valid` and `req_ready` drop asynchronously. The serializer is reset by the same `rst_n`.
- **Timeout timing:** `timeout_err` asserts in the cycle after the counter hits its terminal value, together with `busy` falling.

## Structure
- **Package `uart_pkg`:**
  - `BYTE_W` = 8
  - `CLK_HZ` = 27_000_000
  - default `BAUD` = 115_200
  - arbiter state enum {ARB_IDLE, ARB_LOCKED}
- **Sub-module `uart_rr_picker`:** purely combinational. Inputs are the request vector and the pointer. Outputs are a found flag and an index. It is reused by any future arbiters.
- The top level holds the FSM, the counter and the output muxing.

## Test plan
- **Single requester:** only requester 2 sends "Hi" with `last` on "i", `tx_ready` always 1.
  - `grant_id` = 2 one cycle after valid.
  - `tx_data` 0x48 then 0x69 on consecutive cycles.
  - Then IDLE, and `rr_ptr` = 3.
- **Round-robin fairness:** all four requesters hold 1-byte messages continuously.
  - Grant order 0,1,2,3,0.
  - One idle cycle between each grant.
- **Message lock:** requester 0 sends 3 bytes while requester 1 is valid throughout.
  - `req_ready[1]` stays 0 until requester 0's last byte is accepted.
  - Requester 1 is granted 2 cycles after that byte.
- **Serializer backpressure:** `tx_ready` low for 234 cycles per byte.
  - `req_ready` is high only on the accept cycle.
  - Data is stable and no byte is duplicated or lost.
- **Timeout:** with TIMEOUT_CYCLES = 16, requester 1 sends one non-last byte, then drops valid.
  - `timeout_err` pulses 16 cycles later.
  - `busy` falls.
  - A pending requester 2 is granted next.
- **Reset:** assert `rst_n` low mid-message.
  - `tx_valid`, `busy` and `req_ready` go to 0 without waiting for a clock edge.
  - After release, the first grant goes to the lowest requesting index from 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding used by the
// transmit-side blocks.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int CLK_HZ = 27_000_000;
    localparam int BAUD   = 115_200;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// above ptr, wrapping from NUM_REQ-1 back to 0.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // One extra bit so ptr + offset cannot overflow before the wrap compare.
    localparam logic [ID_W:0] NREQ = (ID_W + 1)'(NUM_REQ);

    logic [ID_W:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (ID_W + 1)'(k);
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req[pos[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one byte-wide UART transmitter
// among NUM_REQ requesters, with forced release of a stalled grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 27_000,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int               CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]   grant_nxt;
    logic [CNT_W-1:0]  idle_cnt, idle_cnt_nxt;
    logic              timeout_nxt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              locked;
    logic              g_valid;
    logic              g_last;
    logic [BYTE_W-1:0] g_data;
    logic [ID_W-1:0]   ptr_adv;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the granted requester's signals; the data path stays combinational.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign locked   = (state == ARB_LOCKED);
    assign busy     = locked;
    assign tx_valid = locked & g_valid;
    assign tx_data  = g_data;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = locked && (grant_id == ID_W'(i)) && tx_ready;
        end
    end

    // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
    assign ptr_adv = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant_id;
        idle_cnt_nxt = idle_cnt;
        timeout_nxt  = 1'b0;
        case (state)
            ARB_IDLE: begin
                idle_cnt_nxt = '0;
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (g_valid) begin
                    idle_cnt_nxt = '0;
                    if (tx_ready && g_last) begin
                        state_nxt  = ARB_IDLE;
                        rr_ptr_nxt = ptr_adv;
                    end
                end else if (idle_cnt == CNT_MAX) begin
                    state_nxt    = ARB_IDLE;
                    rr_ptr_nxt   = ptr_adv;
                    timeout_nxt  = 1'b1;
                    idle_cnt_nxt = '0;
                end else begin
                    idle_cnt_nxt = idle_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            grant_id    <= grant_nxt;
            idle_cnt    <= idle_cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters, short timeout.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_ready = 1'b0;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (tx_valid !== 1'b0)    begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
        total++; if (req_ready !== 4'b0)   begin bad++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
        total++; if (grant_id !== 2'd0)    begin bad++; $display("FAIL rst_grant got=%0d want=0", grant_id); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout_err); end
    endtask

    task automatic test_single();
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 4'b0100;
        set_byte(2, 8'h48);
        req_last  = 4'b0000;
        #1;
        total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b tx_valid=%b want=0/0", busy, tx_valid); end
        step();
        total++; if (busy !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL single_grant busy=%b grant=%0d want=1/2", busy, grant_id); end
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin bad++; $display("FAIL single_byte0 valid=%b data=%h want=1/48", tx_valid, tx_data); end
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready0 got=%b want=0100", req_ready); end
        step();
        set_byte(2, 8'h69);
        req_last = 4'b0100;
        #1;
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin bad++; $display("FAIL single_byte1 valid=%b data=%h want=1/69", tx_valid, tx_data); end
        step();
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        #1;
        total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin bad++; $display("FAIL single_release busy=%b tx_valid=%b want=0/0", busy, tx_valid); end
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant_hold got=%0d want=2", grant_id); end
        step();
        total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL single_rr_ptr got=%0d want=3", grant_id); end
    endtask

    task automatic test_fairness();
        int exp_g[5];
        exp_g = '{0, 1, 2, 3, 0};
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < N; i++) set_byte(i, 8'hA0 + 8'(i));
        for (int m = 0; m < 5; m++) begin
            #1;
            total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin bad++; $display("FAIL rr_gap%0d busy=%b tx_valid=%b want=0/0", m, busy, tx_valid); end
            step();
            total++; if (grant_id !== 2'(exp_g[m])) begin bad++; $display("FAIL rr_order%0d got=%0d want=%0d", m, grant_id, exp_g[m]); end
            total++; if (tx_data !== 8'hA0 + 8'(exp_g[m])) begin bad++; $display("FAIL rr_data%0d got=%h want=%h", m, tx_data, 8'hA0 + 8'(exp_g[m])); end
            step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 4'b0011;
        req_last  = 4'b0010;
        set_byte(0, 8'h10);
        set_byte(1, 8'hEE);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL lock_idle_ready got=%b want=0000", req_ready); end
        step();
        total++; if (req_ready !== 4'b0001 || tx_data !== 8'h10) begin bad++; $display("FAIL lock_b0 ready=%b data=%h want=0001/10", req_ready, tx_data); end
        step();
        set_byte(0, 8'h11);
        #1;
        total++; if (req_ready !== 4'b0001 || tx_data !== 8'h11) begin bad++; $display("FAIL lock_b1 ready=%b data=%h want=0001/11", req_ready, tx_data); end
        step();
        set_byte(0, 8'h12);
        req_last = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0001 || tx_data !== 8'h12) begin bad++; $display("FAIL lock_b2 ready=%b data=%h want=0001/12", req_ready, tx_data); end
        step();
        req_valid = 4'b0010;
        #1;
        total++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL lock_gap busy=%b ready=%b want=0/0000", busy, req_ready); end
        step();
        total++; if (grant_id !== 2'd1 || req_ready !== 4'b0010 || tx_data !== 8'hEE) begin bad++; $display("FAIL lock_next grant=%0d ready=%b data=%h want=1/0010/ee", grant_id, req_ready, tx_data); end
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes[2];
        int         accepted;
        int         stall_bad;
        bytes     = '{8'h5A, 8'hC3};
        accepted  = 0;
        do_reset();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        set_byte(3, bytes[0]);
        step();
        for (int b = 0; b < 2; b++) begin
            set_byte(3, bytes[b]);
            req_last = (b == 1) ? 4'b1000 : 4'b0000;
            tx_ready = 1'b0;
            stall_bad = 0;
            for (int c = 0; c < 234; c++) begin
                #1;
                if (req_ready !== 4'b0000 || tx_valid !== 1'b1 || tx_data !== bytes[b]) stall_bad++;
                step();
            end
            total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall%0d bad_cycles=%0d want=0", b, stall_bad); end
            tx_ready = 1'b1;
            #1;
            total++; if (req_ready !== 4'b1000 || tx_data !== bytes[b]) begin bad++; $display("FAIL bp_accept%0d ready=%b data=%h want=1000/%h", b, req_ready, tx_data, bytes[b]); end
            if (tx_valid === 1'b1) accepted++;
            step();
        end
        req_valid = 4'b0000;
        tx_ready  = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release busy=%b want=0", busy); end
        total++; if (accepted != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", accepted); end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        set_byte(1, 8'h77);
        set_byte(2, 8'h22);
        step();
        total++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin bad++; $display("FAIL to_grant grant=%0d ready=%b want=1/0010", grant_id, req_ready); end
        step();
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        early = 0;
        for (int k = 0; k < TO; k++) begin
            #1;
            if (busy !== 1'b1 || timeout_err !== 1'b0 || grant_id !== 2'd1) early++;
            step();
        end
        total++; if (early != 0) begin bad++; $display("FAIL to_hold bad_cycles=%0d want=0", early); end
        total++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL to_pulse err=%b busy=%b want=1/0", timeout_err, busy); end
        step();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_one_cycle err=%b want=0", timeout_err); end
        total++; if (busy !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL to_next busy=%b grant=%0d want=1/2", busy, grant_id); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready  = 1'b1;
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        set_byte(2, 8'h33);
        step();
        step();
        tx_ready = 1'b0;
        req_last = 4'b0000;
        step();
        total++; if (busy !== 1'b1 || tx_valid !== 1'b1 || grant_id !== 2'd2) begin bad++; $display("FAIL rm_pre busy=%b valid=%b grant=%0d want=1/1/2", busy, tx_valid, grant_id); end
        tx_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL rm_async busy=%b valid=%b ready=%b want=0/0/0000", busy, tx_valid, req_ready); end
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        step();
        rst_n = 1'b1;
        step();
        total++; if (grant_id !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL rm_first grant=%0d busy=%b want=1/1", grant_id, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
